mem_req_queue: RTL and testbench

- Parametrised, circular-buffer successor to the single-depth memory request queue.
- Sits between the trace parser and the DRAM memory controller.
- Accepts time-stamped CPU requests over a valid/ready handshake and keeps a simulation time counter that skips forward when the queue is empty.
- Ages every resident entry and releases the oldest entry in FIFO order once it has aged SERVICE_LAT cycles and the controller is ready.

---
 rtl/mem_req_queue_if.sv | 32 +++
 rtl/mem_req_queue.sv | 125 ++++++++++++
 tb/tb_mem_req_queue.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_queue_if.sv
// Request/release channel between the trace parser, the request queue and the DRAM controller.
// The slave modport is the queue's view. The master modport is the parser/controller side.
interface mem_req_queue_if #(
  parameter int ADDR_W = 33,
  parameter int TIME_W = 64,
  parameter int AGE_W  = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_opcode;
  logic [ADDR_W-1:0] in_addr;
  logic [TIME_W-1:0] in_time;

  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_opcode;
  logic [ADDR_W-1:0] out_addr;
  logic [TIME_W-1:0] out_time;
  logic [AGE_W-1:0]  out_age;

  modport master (
    output in_valid, in_opcode, in_addr, in_time, out_ready,
    input  in_ready, out_valid, out_opcode, out_addr, out_time, out_age
  );

  modport slave (
    input  in_valid, in_opcode, in_addr, in_time, out_ready,
    output in_ready, out_valid, out_opcode, out_addr, out_time, out_age
  );

endinterface

// File: rtl/mem_req_queue.sv
// Circular-buffer queue of time-stamped memory requests. Every resident entry ages each cycle.
// The head entry is released in FIFO order once its age reaches SERVICE_LAT.
module mem_req_queue #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 33,
  parameter int TIME_W      = 64,
  parameter int AGE_W       = 8,
  parameter int SERVICE_LAT = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  mem_req_queue_if.slave           bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [TIME_W-1:0]        curr_time
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;
  localparam logic [AGE_W-1:0] LAT      = AGE_W'(SERVICE_LAT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [1:0]        opcode_q [DEPTH];
  logic [1:0]        opcode_d [DEPTH];
  logic [ADDR_W-1:0] addr_q   [DEPTH];
  logic [ADDR_W-1:0] addr_d   [DEPTH];
  logic [TIME_W-1:0] tstamp_q [DEPTH];
  logic [TIME_W-1:0] tstamp_d [DEPTH];
  logic [AGE_W-1:0]  age_q    [DEPTH];
  logic [AGE_W-1:0]  age_d    [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TIME_W-1:0] curr_time_q, curr_time_d;

  logic is_empty;
  logic is_full;
  logic push;
  logic pop;
  logic [PTR_W-1:0] rel;

  // A future-stamped request is held while older work is resident, but skips the clock when idle.
  assign is_empty      = (count_q == '0);
  assign is_full       = (count_q == CNT_FULL);
  assign bus.in_ready  = !rst && !is_full && (is_empty || (bus.in_time <= curr_time_q));
  assign bus.out_valid = !is_empty && (age_q[head_q] >= LAT);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign bus.out_opcode = opcode_q[head_q];
  assign bus.out_addr   = addr_q[head_q];
  assign bus.out_time   = tstamp_q[head_q];
  assign bus.out_age    = age_q[head_q];

  assign count     = count_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign curr_time = curr_time_q;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    curr_time_d = curr_time_q + 1'b1;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    tstamp_d    = tstamp_q;
    age_d       = age_q;
    rel         = '0;

    if (is_empty && bus.in_valid && (bus.in_time > curr_time_q)) begin
      curr_time_d = bus.in_time;
    end

    // Occupied slots are those within count_q positions after the head, modulo DEPTH.
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - head_q;
      if (({1'b0, rel} < count_q) && (age_q[i] != AGE_MAX)) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end

    if (push) begin
      opcode_d[tail_q] = bus.in_opcode;
      addr_d[tail_q]   = bus.in_addr;
      tstamp_d[tail_q] = bus.in_time;
      age_d[tail_q]    = '0;
      tail_d           = tail_q + 1'b1;
    end

    if (pop) begin
      head_d = head_q + 1'b1;
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      curr_time_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opcode_q[i] <= '0;
        addr_q[i]   <= '0;
        tstamp_q[i] <= '0;
        age_q[i]    <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      curr_time_q <= curr_time_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      tstamp_q    <= tstamp_d;
      age_q       <= age_d;
    end
  end

endmodule

// File: tb/tb_mem_req_queue.sv
// Bench for mem_req_queue. DUT A is checked against a transaction-level queue model.
// DUT B is a narrow-age instance that covers age saturation.
module tb_mem_req_queue;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 33;
  localparam int TIME_W  = 64;
  localparam int AGE_W   = 8;
  localparam int LAT     = 100;
  localparam int AGE_CAP = 255;
  localparam int B_AGE_W = 4;
  localparam int B_LAT   = 10;
  localparam int B_CAP   = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_req_queue_if #(.ADDR_W(ADDR_W), .TIME_W(TIME_W), .AGE_W(AGE_W))   bus_a ();
  mem_req_queue_if #(.ADDR_W(ADDR_W), .TIME_W(TIME_W), .AGE_W(B_AGE_W)) bus_b ();

  logic [2:0]        count_a, count_b;
  logic              full_a, full_b, empty_a, empty_b;
  logic [TIME_W-1:0] curr_a, curr_b;

  mem_req_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIME_W(TIME_W), .AGE_W(AGE_W),
                  .SERVICE_LAT(LAT)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .count(count_a),
    .full(full_a), .empty(empty_a), .curr_time(curr_a)
  );

  mem_req_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIME_W(TIME_W), .AGE_W(B_AGE_W),
                  .SERVICE_LAT(B_LAT)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .count(count_b),
    .full(full_b), .empty(empty_b), .curr_time(curr_b)
  );

  typedef struct {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [TIME_W-1:0] t;
    int                pcyc;
  } entry_t;

  entry_t            mq[$];
  logic [ADDR_W-1:0] dut_pops[$];
  logic [TIME_W-1:0] m_time;
  int                cyc;
  int                n_cmp = 0;
  int                n_err = 0;
  logic              pred_push, pred_pop;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic int head_age();
    int a;
    a = cyc - mq[0].pcyc;
    return (a > AGE_CAP) ? AGE_CAP : a;
  endfunction

  task automatic checkOutput();
    logic e, f, ir, ov;
    e  = (mq.size() == 0);
    f  = (mq.size() == DEPTH);
    ir = !f && (e || (bus_a.in_time <= m_time));
    ov = 1'b0;
    if (!e) ov = (head_age() >= LAT);
    check_eq("count", count_a, mq.size());
    check_eq("empty", empty_a, e);
    check_eq("full", full_a, f);
    check_eq("curr_time", curr_a, m_time);
    check_eq("in_ready", bus_a.in_ready, ir);
    check_eq("out_valid", bus_a.out_valid, ov);
    if (!e) begin
      check_eq("out_opcode", bus_a.out_opcode, mq[0].op);
      check_eq("out_addr", bus_a.out_addr, mq[0].addr);
      check_eq("out_time", bus_a.out_time, mq[0].t);
      check_eq("out_age", bus_a.out_age, head_age());
    end
    pred_push = bus_a.in_valid && ir;
    pred_pop  = ov && bus_a.out_ready;
  endtask

  task automatic model_step(input logic iv, input logic [1:0] op,
                            input logic [ADDR_W-1:0] addr, input logic [TIME_W-1:0] t);
    logic [TIME_W-1:0] nt;
    nt = m_time + 64'd1;
    if ((mq.size() == 0) && iv && (t > m_time)) nt = t;
    cyc++;
    if (pred_pop) void'(mq.pop_front());
    if (pred_push) mq.push_back('{op: op, addr: addr, t: t, pcyc: cyc});
    m_time = nt;
  endtask

  task automatic applyStimulus(input logic iv, input logic [1:0] op,
                               input logic [ADDR_W-1:0] addr, input logic [TIME_W-1:0] t,
                               input logic ordy);
    bus_a.in_valid  = iv;
    bus_a.in_opcode = op;
    bus_a.in_addr   = addr;
    bus_a.in_time   = t;
    bus_a.out_ready = ordy;
    @(negedge clk);
    checkOutput();
    if (pred_pop) dut_pops.push_back(bus_a.out_addr);
    @(posedge clk);
    model_step(iv, op, addr, t);
    #1;
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 2'd0, '0, '0, ordy);
  endtask

  // Reset lands between edges so its effect must be visible before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_eq("rst_count", count_a, 0);
    check_eq("rst_empty", empty_a, 1);
    check_eq("rst_full", full_a, 0);
    check_eq("rst_out_valid", bus_a.out_valid, 0);
    check_eq("rst_in_ready", bus_a.in_ready, 0);
    check_eq("rst_curr_time", curr_a, 0);
    check_eq("rst_out_addr", bus_a.out_addr, 0);
    check_eq("rst_b_count", count_b, 0);
    mq.delete();
    dut_pops.delete();
    m_time = '0;
    cyc    = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((mq.size() != 0) && (n < 1000)) begin
      idle(1'b1);
      n++;
    end
    check_eq(tag, mq.size(), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic              pend;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [TIME_W-1:0] r_t;
    int                n;

    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_opcode = '0; bus_a.in_addr = '0;
    bus_a.in_time = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_opcode = '0; bus_b.in_addr = '0;
    bus_b.in_time = '0; bus_b.out_ready = 1'b0;
    do_reset();

    // Time skip on an empty queue and exact release latency.
    repeat (5) idle(1'b0);
    check_eq("skip_pre_time", curr_a, 5);
    applyStimulus(1'b1, 2'd2, 33'h1_0000_0ABC, 64'd1000, 1'b0);
    check_eq("skip_time", curr_a, 1000);
    check_eq("skip_count", count_a, 1);
    repeat (99) idle(1'b0);
    check_eq("skip_ov_early", bus_a.out_valid, 0);
    idle(1'b0);
    check_eq("skip_ov_rise", bus_a.out_valid, 1);
    check_eq("skip_out_time", bus_a.out_time, 1000);
    idle(1'b1);

    // Reset with three entries resident.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 2'd0, ADDR_W'(k + 'h40), '0, 1'b0);
    check_eq("pre_rst_count", count_a, 3);
    do_reset();

    // A future-stamped request waits until the queue time catches up.
    applyStimulus(1'b1, 2'd0, 33'h11, 64'd0, 1'b0);
    repeat (19) idle(1'b0);
    check_eq("hold_time", curr_a, 20);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2'd1, 33'h22, 64'd25, 1'b0);
      check_eq("hold_count", count_a, (i < 5) ? 1 : 2);
    end
    drain("hold_drain");
    check_eq("hold_pops", dut_pops.size(), 2);
    if (dut_pops.size() == 2) begin
      check_eq("hold_pop0", dut_pops[0], 33'h11);
      check_eq("hold_pop1", dut_pops[1], 33'h22);
    end

    // Fill to DEPTH, then wrap while the head drains.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      n = 0;
      pred_push = 1'b0;
      while (!pred_push && (n < 400)) begin
        applyStimulus(1'b1, 2'(k % 3), ADDR_W'(k), '0, 1'b1);
        n++;
      end
      check_eq("fill_accept", pred_push, 1);
      if (k == 4) begin
        check_eq("fill_full", full_a, 1);
        check_eq("fill_in_ready", bus_a.in_ready, 0);
      end
    end
    drain("fill_drain");
    check_eq("fill_pops", dut_pops.size(), 6);
    for (int k = 0; k < dut_pops.size() && k < 6; k++) check_eq("fill_order", dut_pops[k], k + 1);

    // Simultaneous push and pop with the head at its release age.
    do_reset();
    applyStimulus(1'b1, 2'd0, 33'hB1, '0, 1'b0);
    applyStimulus(1'b1, 2'd1, 33'hB2, '0, 1'b0);
    n = 0;
    while (!((mq.size() > 0) && (head_age() >= LAT)) && (n < 400)) begin
      idle(1'b0);
      n++;
    end
    check_eq("pp_head_ready", bus_a.out_valid, 1);
    applyStimulus(1'b1, 2'd2, 33'hB3, '0, 1'b1);
    check_eq("pp_count", count_a, 2);
    check_eq("pp_head_addr", bus_a.out_addr, 33'hB2);
    check_eq("pp_head_age", bus_a.out_age, 100);
    drain("pp_drain");

    // Randomised traffic with alternating busy and sparse phases.
    do_reset();
    pend = 1'b0; r_op = '0; r_addr = '0; r_t = '0;
    for (int i = 0; i < 1600; i++) begin
      if (!pend && (((i / 200) % 2 == 0) ? ($urandom_range(0, 2) != 0)
                                         : ($urandom_range(0, 19) == 0))) begin
        pend   = 1'b1;
        r_op   = 2'($urandom_range(0, 2));
        r_addr = ADDR_W'({$urandom(), $urandom()});
        r_t    = m_time + 64'($urandom_range(0, 12));
        if (r_t >= 64'd4) r_t = r_t - 64'd4;
      end
      applyStimulus(pend, r_op, r_addr, r_t, ($urandom_range(0, 3) != 0));
      if (pred_push) pend = 1'b0;
    end

    // Age saturation on the narrow-age instance while the controller stalls.
    bus_b.in_valid = 1'b1; bus_b.in_opcode = 2'd1; bus_b.in_addr = 33'h155;
    bus_b.in_time = '0; bus_b.out_ready = 1'b0;
    idle(1'b1);
    bus_b.in_valid = 1'b0;
    check_eq("sat_count", count_b, 1);
    check_eq("sat_age0", bus_b.out_age, 0);
    for (int i = 1; i <= 40; i++) begin
      idle(1'b1);
      check_eq("sat_age", bus_b.out_age, (i > B_CAP) ? B_CAP : i);
      check_eq("sat_valid", bus_b.out_valid, (((i > B_CAP) ? B_CAP : i) >= B_LAT) ? 1 : 0);
      check_eq("sat_addr", bus_b.out_addr, 33'h155);
      check_eq("sat_opcode", bus_b.out_opcode, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
